// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response codes and FSM state types for axil_reg_bridge.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_EXEC,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave that turns each write/read into a one-cycle
// register-bus strobe. Write and read channels are independent FSMs, each with
// one transaction in flight. All AXI outputs come straight from flops.
// Optional feature: define AXIL_ADDR_CHECK_EN to answer word addresses at or
// beyond NUM_REGS with SLVERR and no strobe; otherwise the index simply wraps.
module axil_reg_bridge
  import axil_pkg::*;
#(
  parameter  int ADDR_W   = 21,
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = $clog2(NUM_REGS),
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  input  logic [DATA_W-1:0] s_axil_wdata,
  input  logic [STRB_W-1:0] s_axil_wstrb,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              reg_wr_en,
  output logic [IDX_W-1:0]  reg_wr_idx,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [STRB_W-1:0] reg_wr_strb,
  output logic              reg_rd_en,
  output logic [IDX_W-1:0]  reg_rd_idx,
  input  logic [DATA_W-1:0] reg_rd_data
);

  wr_state_t             wr_state_reg, wr_state_next;
  logic                  awready_reg, awready_next;
  logic                  wready_reg, wready_next;
  logic                  aw_held_reg, aw_held_next;
  logic                  w_held_reg, w_held_next;
  logic                  wr_err_reg, wr_err_next;
  logic                  wr_en_reg, wr_en_next;
  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic [IDX_W-1:0]      wr_idx_reg, wr_idx_next;
  logic [DATA_W-1:0]     wr_data_reg, wr_data_next;
  logic [STRB_W-1:0]     wr_strb_reg, wr_strb_next;

  rd_state_t             rd_state_reg, rd_state_next;
  logic                  arready_reg, arready_next;
  logic                  rd_err_reg, rd_err_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  rvalid_reg, rvalid_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic [IDX_W-1:0]      rd_idx_reg, rd_idx_next;
  logic [DATA_W-1:0]     rdata_reg, rdata_next;

  logic aw_fire, w_fire, ar_fire;
  logic aw_err, ar_err;
  logic unused_bits;

  assign aw_fire = s_axil_awvalid & awready_reg;
  assign w_fire  = s_axil_wvalid  & wready_reg;
  assign ar_fire = s_axil_arvalid & arready_reg;

`ifdef AXIL_ADDR_CHECK_EN
  assign aw_err = (s_axil_awaddr[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS));
  assign ar_err = (s_axil_araddr[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS));
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Protection bits and byte-offset/upper address bits carry no meaning here.
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // Write channel: gather AW and W in any order, strobe once, then respond.
  always_comb begin
    wr_state_next = wr_state_reg;
    awready_next  = awready_reg;
    wready_next   = wready_reg;
    aw_held_next  = aw_held_reg;
    w_held_next   = w_held_reg;
    wr_err_next   = wr_err_reg;
    wr_en_next    = 1'b0;
    bvalid_next   = bvalid_reg;
    bresp_next    = bresp_reg;
    wr_idx_next   = wr_idx_reg;
    wr_data_next  = wr_data_reg;
    wr_strb_next  = wr_strb_reg;
    case (wr_state_reg)
      W_IDLE: begin
        awready_next = ~aw_held_reg & ~aw_fire;
        wready_next  = ~w_held_reg & ~w_fire;
        if (aw_fire) begin
          aw_held_next = 1'b1;
          wr_idx_next  = s_axil_awaddr[2 +: IDX_W];
          wr_err_next  = aw_err;
        end
        if (w_fire) begin
          w_held_next  = 1'b1;
          wr_data_next = s_axil_wdata;
          wr_strb_next = s_axil_wstrb;
        end
        if ((aw_held_reg | aw_fire) && (w_held_reg | w_fire)) begin
          aw_held_next  = 1'b0;
          w_held_next   = 1'b0;
          // The error flag is only in the register if AW arrived earlier.
          wr_en_next    = aw_fire ? ~aw_err : ~wr_err_reg;
          wr_state_next = W_EXEC;
        end
      end
      W_EXEC: begin
        bvalid_next   = 1'b1;
        bresp_next    = wr_err_reg ? RESP_SLVERR : RESP_OKAY;
        wr_state_next = W_RESP;
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_next   = 1'b0;
          awready_next  = 1'b1;
          wready_next   = 1'b1;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Write channel state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      wr_err_reg   <= 1'b0;
      wr_en_reg    <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      wr_idx_reg   <= '0;
      wr_data_reg  <= '0;
      wr_strb_reg  <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      wr_err_reg   <= wr_err_next;
      wr_en_reg    <= wr_en_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      wr_idx_reg   <= wr_idx_next;
      wr_data_reg  <= wr_data_next;
      wr_strb_reg  <= wr_strb_next;
    end
  end

  // Read channel: accept AR, strobe once, capture data a cycle later, respond.
  always_comb begin
    rd_state_next = rd_state_reg;
    arready_next  = arready_reg;
    rd_err_next   = rd_err_reg;
    rd_en_next    = 1'b0;
    rvalid_next   = rvalid_reg;
    rresp_next    = rresp_reg;
    rd_idx_next   = rd_idx_reg;
    rdata_next    = rdata_reg;
    case (rd_state_reg)
      R_IDLE: begin
        arready_next = ~ar_fire;
        if (ar_fire) begin
          rd_idx_next   = s_axil_araddr[2 +: IDX_W];
          rd_err_next   = ar_err;
          rd_en_next    = ~ar_err;
          rd_state_next = R_EXEC;
        end
      end
      R_EXEC: rd_state_next = R_WAIT;
      R_WAIT: begin
        rdata_next    = rd_err_reg ? '0 : reg_rd_data;
        rresp_next    = rd_err_reg ? RESP_SLVERR : RESP_OKAY;
        rvalid_next   = 1'b1;
        rd_state_next = R_RESP;
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_next   = 1'b0;
          arready_next  = 1'b1;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Read channel state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_en_reg    <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rd_idx_reg   <= '0;
      rdata_reg    <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= arready_next;
      rd_err_reg   <= rd_err_next;
      rd_en_reg    <= rd_en_next;
      rvalid_reg   <= rvalid_next;
      rresp_reg    <= rresp_next;
      rd_idx_reg   <= rd_idx_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign s_axil_awready = awready_reg;
  assign s_axil_wready  = wready_reg;
  assign s_axil_bvalid  = bvalid_reg;
  assign s_axil_bresp   = bresp_reg;
  assign s_axil_arready = arready_reg;
  assign s_axil_rvalid  = rvalid_reg;
  assign s_axil_rdata   = rdata_reg;
  assign s_axil_rresp   = rresp_reg;
  assign reg_wr_en      = wr_en_reg;
  assign reg_wr_idx     = wr_idx_reg;
  assign reg_wr_data    = wr_data_reg;
  assign reg_wr_strb    = wr_strb_reg;
  assign reg_rd_en      = rd_en_reg;
  assign reg_rd_idx     = rd_idx_reg;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: table vectors, hand-timed corner sequences and random
// traffic checked against an array model of the register map.
module tb_axil_reg_bridge;
  import axil_pkg::*;

  localparam int ADDR_W = 21;
  localparam int NUM_REGS = 16;
`ifdef AXIL_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata, reg_wr_data;
  logic [31:0] reg_rd_data = '0;
  logic [3:0]  wstrb = '0, reg_wr_strb;
  logic [1:0]  bresp, rresp;
  logic        reg_wr_en, reg_rd_en;
  logic [3:0]  reg_wr_idx, reg_rd_idx;

  always #10 clk = ~clk;

  axil_reg_bridge dut (
    .clk(clk), .rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_awprot(3'b000),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_arprot(3'b000),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb),
    .reg_rd_en(reg_rd_en), .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data)
  );

  // Register file attached to the strobe bus (read data valid the cycle after reg_rd_en).
  logic [31:0] mem [NUM_REGS] = '{default: 32'h0};
  int wr_strobes = 0;
  always @(posedge clk) begin
    if (reg_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (reg_wr_strb[b]) mem[reg_wr_idx][8*b +: 8] <= reg_wr_data[8*b +: 8];
      wr_strobes <= wr_strobes + 1;
    end
    if (reg_rd_en) reg_rd_data <= mem[reg_rd_idx];
  end

  // Reference model: what a bus master should observe.
  logic [31:0] model [NUM_REGS] = '{default: 32'h0};
  int exp_strobes = 0;

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
    return !CHECK || ((int'(a) / 4) < NUM_REGS);
  endfunction

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return (int'(a) / 4) % NUM_REGS;
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx_of(a)][8*b +: 8] = d[8*b +: 8];
      exp_strobes++;
    end
  endtask

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // Full write transaction starting at a negedge; AW and W each delayed independently.
  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    int n;
    fork
      begin
        int k;
        repeat (aw_dly) @(negedge clk);
        awaddr = a; awvalid = 1'b1; k = 0;
        while (!awready && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) timed_out("aw_handshake");
        @(negedge clk); awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1; k = 0;
        while (!wready && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) timed_out("w_handshake");
        @(negedge clk); wvalid = 1'b0;
      end
    join
    bready = 1'b1; n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timed_out("b_response");
    resp = bresp;
    @(negedge clk); bready = 1'b0;
    $display("[TB] WR addr=0x%06h data=0x%08h strb=%h resp=%0d", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timed_out("ar_handshake");
    @(negedge clk); arvalid = 1'b0;
    rready = 1'b1; n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timed_out("r_response");
    d = rdata; resp = rresp;
    @(negedge clk); rready = 1'b0;
    $display("[TB] RD addr=0x%06h data=0x%08h resp=%0d", a, d, resp);
  endtask

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
    logic [1:0]        exp_resp;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, held;
    logic [ADDR_W-1:0] a;
    logic [31:0] d, exp_rd;
    logic [3:0]  s;
    int s0;
    bit ok, got_b, got_r;
    logic [1:0] b_c, r_c;
    logic [31:0] r_d;

    // Expected values derived by hand from the byte-lane and addressing rules.
    tbl[0]  = '{1'b1, 21'h008, 32'hDEADBEEF, 4'hF, RESP_OKAY, 32'h0};
    tbl[1]  = '{1'b0, 21'h008, 32'h0, 4'h0, RESP_OKAY, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 21'h00A, 32'h00FF00FF, 4'h5, RESP_OKAY, 32'h0};
    tbl[3]  = '{1'b0, 21'h008, 32'h0, 4'h0, RESP_OKAY, 32'hDEFFBEFF};
    tbl[4]  = '{1'b1, 21'h017, 32'hCAFEF00D, 4'hF, RESP_OKAY, 32'h0};
    tbl[5]  = '{1'b0, 21'h014, 32'h0, 4'h0, RESP_OKAY, 32'hCAFEF00D};
    tbl[6]  = '{1'b1, 21'h040, 32'h11111111, 4'hF, CHECK ? RESP_SLVERR : RESP_OKAY, 32'h0};
    tbl[7]  = '{1'b0, 21'h000, 32'h0, 4'h0, RESP_OKAY, CHECK ? 32'h0 : 32'h11111111};
    tbl[8]  = '{1'b0, 21'h040, 32'h0, 4'h0, CHECK ? RESP_SLVERR : RESP_OKAY, CHECK ? 32'h0 : 32'h11111111};
    tbl[9]  = '{1'b1, 21'h03C, 32'h80000001, 4'h3, RESP_OKAY, 32'h0};
    tbl[10] = '{1'b0, 21'h03C, 32'h0, 4'h0, RESP_OKAY, 32'h00000001};
    tbl[11] = '{1'b0, 21'h07C, 32'h0, 4'h0, CHECK ? RESP_SLVERR : RESP_OKAY, CHECK ? 32'h0 : 32'h00000001};

    // Reset state, then readies rise one cycle after release.
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_valids", 32'({bvalid, rvalid, reg_wr_en, reg_rd_en}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", 32'({bresp, rresp}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("readies_after_rst", 32'({awready, wready, arready}), 32'b111);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 3, resp);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        check($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].exp_resp));
      end else begin
        axi_read(tbl[i].addr, rd, resp);
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        check($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(tbl[i].exp_resp));
      end
    end
    check("tbl_strobe_count", 32'(wr_strobes), 32'(exp_strobes));

    // Same-cycle AW+W: strobe in cycle 1, bvalid in cycle 2, readies back in cycle 3.
    awaddr = 21'h008; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("c1_wr_en", 32'(reg_wr_en), 32'd1);
    check("c1_wr_idx", 32'(reg_wr_idx), 32'd2);
    check("c1_wr_data", reg_wr_data, 32'hDEADBEEF);
    check("c1_readies_low", 32'({awready, wready}), 32'd0);
    @(negedge clk);
    check("c2_wr_en_off", 32'(reg_wr_en), 32'd0);
    check("c2_bvalid", 32'(bvalid), 32'd1);
    check("c2_bresp", 32'(bresp), 32'(RESP_OKAY));
    @(negedge clk);
    bready = 1'b0;
    check("c3_bvalid_off", 32'(bvalid), 32'd0);
    check("c3_readies_back", 32'({awready, wready}), 32'b11);
    model_write(21'h008, 32'hDEADBEEF, 4'hF);
    $display("[TB] WR same-cycle addr=0x008 timing sequence done");

    // W five cycles before AW.
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    s0 = wr_strobes; ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (reg_wr_en || wready) ok = 1'b0;
    end
    check("early_w_no_strobe", 32'(ok), 32'd1);
    awaddr = 21'h004; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("early_w_strobe", 32'(reg_wr_en), 32'd1);
    check("early_w_idx", 32'(reg_wr_idx), 32'd1);
    check("early_w_data", reg_wr_data, 32'hA5A5A5A5);
    bready = 1'b1;
    for (int k = 0; k < 20 && !bvalid; k++) @(negedge clk);
    check("early_w_bvalid", 32'(bvalid), 32'd1);
    @(negedge clk); bready = 1'b0;
    check("early_w_single", 32'(wr_strobes - s0), 32'd1);
    model_write(21'h004, 32'hA5A5A5A5, 4'hF);
    $display("[TB] WR W-before-AW addr=0x004 sequence done");

    // Read timing with rready backpressure.
    axi_write(21'h00C, 32'h12345678, 4'hF, 0, 0, resp);
    model_write(21'h00C, 32'h12345678, 4'hF);
    araddr = 21'h00C; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("r1_rd_en", 32'(reg_rd_en), 32'd1);
    check("r1_rd_idx", 32'(reg_rd_idx), 32'd3);
    @(negedge clk);
    check("r2_no_rvalid", 32'({reg_rd_en, rvalid}), 32'd0);
    @(negedge clk);
    check("r3_rvalid", 32'(rvalid), 32'd1);
    check("r3_rdata", rdata, 32'h12345678);
    check("r3_rresp", 32'(rresp), 32'(RESP_OKAY));
    held = rdata; ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!rvalid || rdata !== held || arready || reg_rd_en) ok = 1'b0;
    end
    check("r_backpressure_stable", 32'(ok), 32'd1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("r_released", 32'({rvalid, arready}), 32'b01);
    $display("[TB] RD addr=0x00C backpressure sequence done");

    // Concurrent write idx 1 and read idx 5.
    exp_rd = model[5];
    awaddr = 21'h004; wdata = 32'h0BADC0DE; wstrb = 4'hF; araddr = 21'h014;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_both_strobes", 32'({reg_wr_en, reg_rd_en}), 32'b11);
    check("conc_idx", 32'({reg_wr_idx, reg_rd_idx}), 32'h15);
    got_b = 0; got_r = 0; b_c = 2'b11; r_c = 2'b11; r_d = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bvalid && !got_b) begin got_b = 1; b_c = bresp; end
      if (rvalid && !got_r) begin got_r = 1; r_c = rresp; r_d = rdata; end
    end
    bready = 1'b0; rready = 1'b0;
    model_write(21'h004, 32'h0BADC0DE, 4'hF);
    check("conc_got_both", 32'({got_b, got_r}), 32'b11);
    check("conc_resps", 32'({b_c, r_c}), 32'd0);
    check("conc_rdata", r_d, exp_rd);
    $display("[TB] concurrent WR idx1 / RD idx5 done");

    // Reset while a write response is pending.
    awaddr = 21'h018; wdata = 32'h00000077; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(21'h018, 32'h00000077, 4'hF);
    @(negedge clk);
    check("pre_rst_bvalid", 32'(bvalid), 32'd1);
    #5 rst = 1'b1;
    #1 check("async_bvalid_drop", 32'(bvalid), 32'd0);
    check("async_awready_drop", 32'(awready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s0 = wr_strobes;
    @(negedge clk);
    check("post_rst_awready", 32'(awready), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_no_strobe", 32'(wr_strobes - s0), 32'd0);
    check("post_rst_no_bvalid", 32'(bvalid), 32'd0);
    $display("[TB] reset-during-bvalid sequence done");

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = ADDR_W'(($urandom_range(NUM_REGS, 20000) << 2) | $urandom_range(0, 3));
      else
        a = ADDR_W'(($urandom_range(0, NUM_REGS - 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
        model_write(a, d, s);
        check($sformatf("rnd%0d_bresp", i), 32'(resp), in_range(a) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
      end else begin
        axi_read(a, rd, resp);
        check($sformatf("rnd%0d_rdata", i), rd, in_range(a) ? model[idx_of(a)] : 32'h0);
        check($sformatf("rnd%0d_rresp", i), 32'(resp), in_range(a) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
      end
    end
    check("total_strobes", 32'(wr_strobes), 32'(exp_strobes));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
# axil_reg_bridge

AXI4-Lite slave front end that terminates the HPS lightweight H2F bridge inside the student module and converts each AXI-Lite transaction into a single-cycle register-bus strobe. The register file and BCH datapath consume it. It handles one outstanding write and one outstanding read at a time. The write and read channels run independently and concurrently.

## Interface
- ADDR_W, 21, AXI byte-address width.
- DATA_W, 32, data width; only 32 is supported.
- NUM_REGS, 16, number of 32-bit registers; index width IDX_W = $clog2(NUM_REGS).
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; asynchronous, active-high.
- s_axil_awvalid/awready  in/out  1/1  AW handshake.
- s_axil_awaddr  in  ADDR_W  write byte address.
- s_axil_awprot  in  3  ignored.
- s_axil_wvalid/wready  in/out  1/1  W handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte enables.
- s_axil_bvalid/bready  out/in  1/1  B handshake.
- s_axil_bresp  out  2  write response.
- s_axil_arvalid/arready  in/out  1/1  AR handshake.
- s_axil_araddr  in  ADDR_W  read byte address.
- s_axil_arprot  in  3  ignored.
- s_axil_rvalid/rready  out/in  1/1  R handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_idx  out  IDX_W  register index.
- reg_wr_data  out  32  write data.
- reg_wr_strb  out  4  byte enables.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_idx  out  IDX_W  register index.
- reg_rd_data  in  32  read data from the register file, valid the cycle after reg_rd_en.

## Operation
- Index = addr[2 +: IDX_W]. addr[1:0] is ignored.
- Write FSM, states:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W are captured independently, in either order or in the same cycle. When both are held, go to W_EXEC.
  - W_EXEC: drives reg_wr_en=1 for one cycle (unless suppressed by the range check), then goes to W_RESP.
  - W_RESP: bvalid=1 and bresp held until bready, then returns to W_IDLE.
- Read FSM, states:
  - R_IDLE: arready=1. On handshake, latch the address and go to R_EXEC.
  - R_EXEC: drives reg_rd_en for one cycle, then goes to R_WAIT.
  - R_WAIT: registers reg_rd_data into rdata, then goes to R_RESP.
  - R_RESP: rvalid=1, with rdata/rresp stable until rready, then returns to R_IDLE.
- A read and a write may strobe in the same cycle, including to the same index. Ordering between them is defined by the register file, not by this block.
- All AXI outputs are registered. No combinational path from valid to ready.
- Reset values: all readies 0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr_en=0, reg_rd_en=0, idx/data/strb outputs 0. Readies rise in the first cycle after rst deasserts.
- Reset mid-transaction: the pending transaction is dropped and no strobe is issued. bvalid and rvalid fall asynchronously.

## Timing
- Write: AW+W accepted at edge 0 → reg_wr_en high in cycle 1 → bvalid high from cycle 2. With bready held 1, awready/wready return in cycle 3.
- AW and W arriving on different edges: latency counts from the later handshake.
- Read: AR accepted at edge 0 → reg_rd_en in cycle 1 → reg_rd_data sampled at the end of cycle 2 → rvalid high from cycle 3.
- Sustained throughput: one write per 3 cycles and one read per 4 cycles, with ready/bready/rready held high.
- Backpressure: while bready or rready is low, the response and data are held stable indefinitely and no new transaction on that channel is accepted.

## Configuration
- AXIL_ADDR_CHECK_EN defined: word address addr[ADDR_W-1:2] >= NUM_REGS is out of range.
  - Out-of-range write: reg_wr_en suppressed, bresp=SLVERR.
  - Out-of-range read: reg_rd_en suppressed, rdata=0, rresp=SLVERR.
  - Response timing is identical to an in-range access.
- Undefined: the upper address bits are ignored, the index wraps modulo 2^IDX_W, and the response is always OKAY.

## Structure
- Package axil_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The wr_state_t and rd_state_t enums.
- No sub-module: two independent always_ff FSM processes in one module.

## Test plan
- Write addr 0x8, data 0xDEADBEEF, strb 0xF, AW and W in the same cycle → reg_wr_en in cycle 1 with idx=2, data 0xDEADBEEF; bvalid in cycle 2, bresp=OKAY.
- W sent 5 cycles before AW (addr 0x4) → a single strobe on idx=1, one cycle after the AW handshake.
- Read addr 0xC with reg_rd_data=0x12345678 → reg_rd_en idx=3 in cycle 1; rvalid in cycle 3 with rdata 0x12345678; rready held low 4 cycles → rdata stable, arready stays 0.
- Concurrent write idx 1 and read idx 5 → both strobes in the same cycle and both responses correct.
- With AXIL_ADDR_CHECK_EN, NUM_REGS=16: write 0x40 → no strobe, bresp=SLVERR. Read 0x40 → rdata 0, rresp=SLVERR. Without the macro: write 0x40 strobes idx 0, bresp=OKAY.
- Assert rst while bvalid is pending → bvalid falls immediately; after release, awready=1 and there is no spurious reg_wr_en.
